// File: rtl/led_command_parser_if.sv
// Byte handshake between the UART receiver/transmitter pair
// and the LED command parser.
interface led_command_parser_if;
    logic [7:0] rcv_data;
    logic       rcv_ready;
    logic       snd_busy;
    logic [7:0] snd_data;
    logic       snd_ready;

    modport master (
        output rcv_data, rcv_ready, snd_busy,
        input  snd_data, snd_ready
    );

    modport slave (
        input  rcv_data, rcv_ready, snd_busy,
        output snd_data, snd_ready
    );
endinterface

// File: rtl/led_command_parser.sv
// ASCII "C H H T" command parser driving three frame-aligned
// RGB PWM outputs, answering 'K' or 'E' per frame.
module led_command_parser #(
    parameter int PWM_DIV = 188
) (
    input  logic clk,
    input  logic reset,
    led_command_parser_if.slave bus,
    output logic pwm_r,
    output logic pwm_g,
    output logic pwm_b
);
    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PWM_DIV - 1);
    localparam logic [7:0] CH_K = 8'h4B;
    localparam logic [7:0] CH_E = 8'h45;

    typedef enum logic [2:0] {
        IDLE, HEX_HI, HEX_LO, TERM, RESP
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      chan_q, chan_d;
    logic [7:0]      val_q, val_d;
    logic [7:0]      snd_data_q, snd_data_d;
    logic            snd_ready_q, snd_ready_d;
    logic [2:0][7:0] shadow_q, shadow_d;
    logic [2:0][7:0] active_q, active_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [2:0]      pwm_q, pwm_d;

    logic [4:0] nib;
    logic       term, is_ch, err, tick;
    logic [1:0] ch;

    // {valid, value} for one ASCII hex digit
    function automatic logic [4:0] hex_nib(input logic [7:0] b);
        logic [4:0] r;
        r = '0;
        if (b >= 8'h30 && b <= 8'h39) r = {1'b1, 4'(b - 8'h30)};
        if (b >= 8'h41 && b <= 8'h46) r = {1'b1, 4'(b - 8'h37)};
        if (b >= 8'h61 && b <= 8'h66) r = {1'b1, 4'(b - 8'h57)};
        return r;
    endfunction

    always_comb begin
        nib   = hex_nib(bus.rcv_data);
        term  = (bus.rcv_data == 8'h0D) || (bus.rcv_data == 8'h0A);
        is_ch = 1'b1;
        ch    = 2'd0;
        unique case (bus.rcv_data)
            8'h52:   ch = 2'd0;
            8'h47:   ch = 2'd1;
            8'h42:   ch = 2'd2;
            default: is_ch = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        val_d       = val_q;
        snd_data_d  = snd_data_q;
        snd_ready_d = 1'b0;
        shadow_d    = shadow_q;
        err         = 1'b0;
        unique case (state_q)
            IDLE: if (bus.rcv_ready) begin
                unique case (1'b1)
                    is_ch: begin
                        chan_d  = ch;
                        state_d = HEX_HI;
                    end
                    term:    state_d = IDLE;
                    default: err = 1'b1;
                endcase
            end
            HEX_HI: if (bus.rcv_ready) begin
                if (nib[4]) begin
                    val_d   = {nib[3:0], val_q[3:0]};
                    state_d = HEX_LO;
                end else begin
                    err = 1'b1;
                end
            end
            HEX_LO: if (bus.rcv_ready) begin
                if (nib[4]) begin
                    val_d   = {val_q[7:4], nib[3:0]};
                    state_d = TERM;
                end else begin
                    err = 1'b1;
                end
            end
            TERM: if (bus.rcv_ready) begin
                if (term) begin
                    shadow_d[chan_q] = val_q;
                    snd_data_d       = CH_K;
                    state_d          = RESP;
                end else begin
                    err = 1'b1;
                end
            end
            RESP: if (!bus.snd_busy) begin
                snd_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (err) begin
            snd_data_d = CH_E;
            state_d    = RESP;
        end
    end

    // Active duties only change at the 255->0 tick, so frames are never cut.
    always_comb begin
        tick     = (pre_q == PRE_MAX);
        pre_d    = tick ? '0 : pre_q + 1'b1;
        cnt_d    = tick ? cnt_q + 8'd1 : cnt_q;
        active_d = (tick && cnt_q == 8'hFF) ? shadow_q : active_q;
        for (int i = 0; i < 3; i++) begin
            pwm_d[i] = (cnt_q < active_q[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            chan_q      <= '0;
            val_q       <= '0;
            snd_data_q  <= '0;
            snd_ready_q <= 1'b0;
            shadow_q    <= '0;
            active_q    <= '0;
            pre_q       <= '0;
            cnt_q       <= '0;
            pwm_q       <= '0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            val_q       <= val_d;
            snd_data_q  <= snd_data_d;
            snd_ready_q <= snd_ready_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            pre_q       <= pre_d;
            cnt_q       <= cnt_d;
            pwm_q       <= pwm_d;
        end
    end

    assign bus.snd_data  = snd_data_q;
    assign bus.snd_ready = snd_ready_q;
    assign pwm_r         = pwm_q[0];
    assign pwm_g         = pwm_q[1];
    assign pwm_b         = pwm_q[2];
endmodule
